// File: rtl/dds_pkg.sv
// Shared defaults and helpers for the DDS phase accumulator blocks.
package dds_pkg;

   localparam int unsigned DEF_ACC_WIDTH = 32;
   localparam int unsigned DEF_OUT_WIDTH = 12;
   localparam int unsigned DEF_NUM_CH    = 2;

   // Width of a channel index; a single-channel design still gets one select bit.
   function automatic int unsigned ch_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/phase_acc_channel.sv
// One DDS channel: double-buffered FTW/offset, modular accumulator, wrap and truncated output.
module phase_acc_channel
   import dds_pkg::*;
#(
   parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_wr,
   input  logic [ACC_WIDTH-1:0] i_ftw,
   input  logic [ACC_WIDTH-1:0] i_poff,
   input  logic                 i_commit,
   input  logic                 i_enable,
   input  logic                 i_sync,
   output logic [OUT_WIDTH-1:0] o_phase,
   output logic                 o_wrap
);

   logic [ACC_WIDTH-1:0] r_sh_ftw;
   logic [ACC_WIDTH-1:0] r_sh_poff;
   logic [ACC_WIDTH-1:0] r_act_ftw;
   logic [ACC_WIDTH-1:0] r_act_poff;
   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_wrap_s1;

   logic [ACC_WIDTH:0]   w_sum;
   logic [ACC_WIDTH-1:0] w_off;

   assign w_sum = {1'b0, r_acc} + {1'b0, r_act_ftw};
   assign w_off = r_acc + r_act_poff;

   // Shadow registers take host writes; commit copies them to the active set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sh_ftw   <= '0;
         r_sh_poff  <= '0;
         r_act_ftw  <= '0;
         r_act_poff <= '0;
      end else begin
         if (i_wr) begin
            r_sh_ftw  <= i_ftw;
            r_sh_poff <= i_poff;
         end
         if (i_commit) begin
            r_act_ftw  <= r_sh_ftw;
            r_act_poff <= r_sh_poff;
         end
      end
   end

   // Accumulator with carry capture; sync clear wins over enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc     <= '0;
         r_wrap_s1 <= 1'b0;
      end else if (i_sync) begin
         r_acc     <= '0;
         r_wrap_s1 <= 1'b0;
      end else if (i_enable) begin
         r_acc     <= w_sum[ACC_WIDTH-1:0];
         r_wrap_s1 <= w_sum[ACC_WIDTH];
      end else begin
         r_wrap_s1 <= 1'b0;
      end
   end

   // Output stage: offset-added phase truncated to its top bits, wrap aligned with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_phase <= '0;
         o_wrap  <= 1'b0;
      end else begin
         o_phase <= w_off[ACC_WIDTH-1 -: OUT_WIDTH];
         o_wrap  <= r_wrap_s1;
      end
   end

endmodule

// File: rtl/phase_acc_multi.sv
// Multi-channel DDS phase accumulator: config decode, global commit/enable, output packing.
module phase_acc_multi
   import dds_pkg::*;
#(
   parameter  int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
   parameter  int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
   parameter  int unsigned NUM_CH    = DEF_NUM_CH,
   localparam int unsigned CH_W      = ch_width(NUM_CH)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [CH_W-1:0]               cfg_ch,
   input  logic [ACC_WIDTH-1:0]          cfg_ftw,
   input  logic [ACC_WIDTH-1:0]          cfg_poff,
   input  logic                          commit,
   input  logic [NUM_CH-1:0]             ch_sync,
   output logic [NUM_CH*OUT_WIDTH-1:0]   phase_out,
   output logic [NUM_CH-1:0]             wrap,
   output logic                          out_valid
);

   logic       w_accept;
   logic       r_en_d1;

   // Writes colliding with commit are refused so the host retries after it.
   assign cfg_ready = ~commit;
   assign w_accept  = cfg_valid & cfg_ready;

   // Out-of-range channel selects match no instance and are silently dropped.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic w_wr;
      assign w_wr = w_accept & (cfg_ch == CH_W'(g));

      phase_acc_channel #(
         .ACC_WIDTH (ACC_WIDTH),
         .OUT_WIDTH (OUT_WIDTH)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .i_wr     (w_wr),
         .i_ftw    (cfg_ftw),
         .i_poff   (cfg_poff),
         .i_commit (commit),
         .i_enable (enable),
         .i_sync   (ch_sync[g]),
         .o_phase  (phase_out[g*OUT_WIDTH +: OUT_WIDTH]),
         .o_wrap   (wrap[g])
      );
   end

   // Enable pipeline matching the two-stage accumulate/output latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_en_d1   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         r_en_d1   <= enable;
         out_valid <= r_en_d1;
      end
   end

endmodule
